// File: rtl/rf_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_sched_pkg
// Shared widths and the write-port grant-source encoding for the register-file
// write scheduler and its scoreboard.
// ---------------------------------------------------------------------------
package rf_sched_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_BUF  = 2'd2
    } gnt_src_e;

endpackage : rf_sched_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// 32-entry busy vector tracking destination registers that have been issued
// but not yet written, plus the RAW/WAW hazard lookup for decode.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset (clears every busy bit)
//   i_set_en   in   an issuing instruction writes i_set_idx
//   i_set_idx  in   destination of the issuing instruction
//   i_clr_en   in   register file is written this cycle (rf_we)
//   i_clr_idx  in   register being written this cycle (rf_rw)
//   i_rs/i_rt  in   decode source registers
//   i_wr       in   decode instruction writes a register
//   i_dst      in   decode destination register
//   o_raw_hit  out  a source is busy and not covered by write-through
//   o_waw_hit  out  the destination is busy and not being written now
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_idx,
    input  logic             i_clr_en,
    input  logic [REG_W-1:0] i_clr_idx,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_wr,
    input  logic [REG_W-1:0] i_dst,
    output logic             o_raw_hit,
    output logic             o_waw_hit
);

    logic [NUM_REGS-1:0] r_busy;

    // Register 0 is hardwired and can never be in flight.
    assign r_busy[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            logic w_set;
            logic w_clr;
            assign w_set = i_set_en && (i_set_idx == REG_W'(gi));
            assign w_clr = i_clr_en && (i_clr_idx == REG_W'(gi));

            // A new producer issuing in the same cycle the old value lands
            // must keep the register busy, so set takes priority over clear.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_busy[gi] <= 1'b0;
                end else if (w_set) begin
                    r_busy[gi] <= 1'b1;
                end else if (w_clr) begin
                    r_busy[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // A busy register that is being written right now is not a hazard: the
    // register file forwards busW to its read ports in the same cycle.
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_dst_hit;

    assign w_rs_hit  = r_busy[i_rs]  && !(i_clr_en && (i_clr_idx == i_rs));
    assign w_rt_hit  = r_busy[i_rt]  && !(i_clr_en && (i_clr_idx == i_rt));
    assign w_dst_hit = r_busy[i_dst] && !(i_clr_en && (i_clr_idx == i_dst));

    assign o_raw_hit = w_rs_hit || w_rt_hit;
    assign o_waw_hit = i_wr && w_dst_hit;

endmodule : rf_scoreboard

// File: rtl/rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// rf_write_scheduler
// Owns the single register-file write port. Arbitrates between the pipeline
// writeback beat and a one-entry buffer holding mul/div results, counts MDU
// ops in flight, and raises the decode stall on uncovered hazards.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   iss_*                 decode issue request (valid, rs, rt, wr, dst, long)
//   stall                 decode must hold; issue fires on iss_valid && !stall
//   wb_valid/dst/data     pipeline writeback beat
//   wb_hold               WB beat lost the port; pipeline re-presents it
//   mdu_valid/dst/data    MDU result
//   mdu_ready             buffer accepts on mdu_valid && mdu_ready
//   rf_we/rf_rw/rf_busw   register-file RegWr / RW / busW
// ---------------------------------------------------------------------------
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int MDU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_rs,
    input  logic [REG_W-1:0]  iss_rt,
    input  logic              iss_wr,
    input  logic [REG_W-1:0]  iss_dst,
    input  logic              iss_long,
    output logic              stall,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_hold,
    input  logic              mdu_valid,
    input  logic [REG_W-1:0]  mdu_dst,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_rw,
    output logic [DATA_W-1:0] rf_busw
);

    localparam int OUT_W = $clog2(MDU_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [OUT_W-1:0] OUT_LIM = OUT_W'(MDU_DEPTH);
    localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_MAX);

    // One-entry MDU result buffer and counters
    logic              r_buf_valid;
    logic [REG_W-1:0]  r_buf_dst;
    logic [DATA_W-1:0] r_buf_data;
    logic [STV_W-1:0]  r_starve_cnt;
    logic [OUT_W-1:0]  r_out_cnt;

    gnt_src_e          w_gnt;
    logic [REG_W-1:0]  w_win_dst;
    logic [DATA_W-1:0] w_win_data;
    logic              w_buf_gnt;
    logic              w_mdu_accept;
    logic              w_issue_fire;
    logic              w_long_issue;
    logic              w_raw_hit;
    logic              w_waw_hit;
    logic              w_mdu_full;
    logic              w_rf_we;

    // ---------------- write-port arbitration ----------------
    // The buffer yields to WB until it has waited STARVE_MAX cycles; an idle
    // WB slot is always given to the buffer.
    always_comb begin
        w_gnt      = GNT_NONE;
        w_win_dst  = '0;
        w_win_data = '0;
        if (r_buf_valid && ((r_starve_cnt == STV_LIM) || !wb_valid)) begin
            w_gnt      = GNT_BUF;
            w_win_dst  = r_buf_dst;
            w_win_data = r_buf_data;
        end else if (wb_valid) begin
            w_gnt      = GNT_WB;
            w_win_dst  = wb_dst;
            w_win_data = wb_data;
        end
    end

    assign w_buf_gnt = (w_gnt == GNT_BUF);

    // A write to register 0 still consumes its entry but never asserts RegWr.
    assign w_rf_we = reset && (w_gnt != GNT_NONE) && (w_win_dst != '0);

    assign rf_we     = w_rf_we;
    assign rf_rw     = reset ? w_win_dst  : '0;
    assign rf_busw   = reset ? w_win_data : '0;
    assign wb_hold   = reset && wb_valid && w_buf_gnt;
    assign mdu_ready = reset && (!r_buf_valid || w_buf_gnt);

    assign w_mdu_accept = mdu_valid && mdu_ready;

    // ---------------- hazard detection / issue ----------------
    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .i_set_en  (w_issue_fire && iss_wr),
        .i_set_idx (iss_dst),
        .i_clr_en  (w_rf_we),
        .i_clr_idx (rf_rw),
        .i_rs      (iss_rs),
        .i_rt      (iss_rt),
        .i_wr      (iss_wr),
        .i_dst     (iss_dst),
        .o_raw_hit (w_raw_hit),
        .o_waw_hit (w_waw_hit)
    );

    assign w_mdu_full = iss_long && (r_out_cnt == OUT_LIM);

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = 1'b1;
        end else if (iss_valid) begin
            stall = w_raw_hit || w_waw_hit || w_mdu_full;
        end
    end

    assign w_issue_fire = reset && iss_valid && !stall;
    assign w_long_issue = w_issue_fire && iss_long;

    // ---------------- buffer ----------------
    // Drain and refill may happen in the same cycle; a refill wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_buf_valid <= 1'b0;
            r_buf_dst   <= '0;
            r_buf_data  <= '0;
        end else if (w_mdu_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_dst   <= mdu_dst;
            r_buf_data  <= mdu_data;
        end else if (w_buf_gnt) begin
            r_buf_valid <= 1'b0;
        end
    end

    // ---------------- starvation counter ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_buf_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_buf_valid && (r_starve_cnt != STV_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // ---------------- outstanding MDU op counter ----------------
    // Decrement is guarded at zero so a stray MDU result cannot wrap the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_cnt <= '0;
        end else if (w_long_issue && !w_mdu_accept) begin
            r_out_cnt <= r_out_cnt + 1'b1;
        end else if (!w_long_issue && w_mdu_accept && (r_out_cnt != '0)) begin
            r_out_cnt <= r_out_cnt - 1'b1;
        end
    end

endmodule : rf_write_scheduler

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;

    logic        clk;
    logic        reset;
    logic        iss_valid;
    logic [4:0]  iss_rs;
    logic [4:0]  iss_rt;
    logic        iss_wr;
    logic [4:0]  iss_dst;
    logic        iss_long;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        wb_hold;
    logic        mdu_valid;
    logic [4:0]  mdu_dst;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_busw;

    int checks = 0;
    int errors = 0;

    rf_write_scheduler #(.MDU_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rs    (iss_rs),
        .iss_rt    (iss_rt),
        .iss_wr    (iss_wr),
        .iss_dst   (iss_dst),
        .iss_long  (iss_long),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data),
        .wb_hold   (wb_hold),
        .mdu_valid (mdu_valid),
        .mdu_dst   (mdu_dst),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_rw     (rf_rw),
        .rf_busw   (rf_busw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs then change at edge+1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_wr = 0; iss_dst = 0; iss_long = 0;
        wb_valid = 0; wb_dst = 0; wb_data = 0;
        mdu_valid = 0; mdu_dst = 0; mdu_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        cyc();
        cyc();
        reset = 1;
        #1;
    endtask

    task automatic test_reset();
        $display("test_reset");
        idle_inputs();
        reset = 0;
        wb_valid = 1; wb_dst = 5'd4; wb_data = 32'h11;
        mdu_valid = 1; mdu_dst = 5'd6;
        cyc();
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b expected 1", stall); end
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL rst_mdu_ready: got %b expected 0", mdu_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b expected 0", rf_we); end
        checks++; if (rf_rw !== 5'd0 || rf_busw !== 32'd0) begin errors++; $display("FAIL rst_rw_busw: got %0d/%h expected 0/0", rf_rw, rf_busw); end
        checks++; if (wb_hold !== 1'b0) begin errors++; $display("FAIL rst_wb_hold: got %b expected 0", wb_hold); end
        idle_inputs();
        cyc();
        reset = 1;
        iss_valid = 1; iss_rs = 5'd5; iss_rt = 5'd6; iss_wr = 1; iss_dst = 5'd6;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b expected 0", stall); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_mdu_ready: got %b expected 1", mdu_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_rf_we: got %b expected 0", rf_we); end
        idle_inputs();
    endtask

    task automatic test_raw_writethrough();
        $display("test_raw_writethrough");
        do_reset();
        iss_valid = 1; iss_wr = 1; iss_dst = 5'd5;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL issue_d5: got stall %b expected 0", stall); end
        cyc();
        iss_wr = 0; iss_dst = 0; iss_rs = 5'd5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_rs5: got stall %b expected 1", stall); end
        iss_rs = 0; iss_rt = 5'd5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_rt5: got stall %b expected 1", stall); end
        iss_rt = 0; iss_wr = 1; iss_dst = 5'd5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_d5: got stall %b expected 1", stall); end
        iss_valid = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_no_valid: got %b expected 0", stall); end
        iss_valid = 1; iss_wr = 0; iss_dst = 0; iss_rs = 5'd5;
        wb_valid = 1; wb_dst = 5'd5; wb_data = 32'hDEAD;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rw !== 5'd5 || rf_busw !== 32'hDEAD) begin errors++; $display("FAIL wb_write: got we=%b rw=%0d busw=%h expected 1/5/dead", rf_we, rf_rw, rf_busw); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL write_through: got stall %b expected 0", stall); end
        checks++; if (wb_hold !== 1'b0) begin errors++; $display("FAIL wb_hold_plain: got %b expected 0", wb_hold); end
        cyc();
        wb_valid = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL busy5_cleared: got stall %b expected 0", stall); end
        idle_inputs();
    endtask

    task automatic test_reg_zero();
        $display("test_reg_zero");
        do_reset();
        iss_valid = 1; iss_wr = 1; iss_dst = 5'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL issue_d0: got stall %b expected 0", stall); end
        cyc();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_d0: got stall %b expected 0", stall); end
        iss_wr = 0; iss_rs = 0; iss_rt = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_r0: got stall %b expected 0", stall); end
        // Mark r8 busy, then a WB to r0 must not clear it.
        iss_wr = 1; iss_dst = 5'd8;
        cyc();
        iss_wr = 0; iss_dst = 0; iss_valid = 0;
        wb_valid = 1; wb_dst = 5'd0; wb_data = 32'h5555;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wb_r0_we: got %b expected 0", rf_we); end
        cyc();
        wb_valid = 0;
        iss_valid = 1; iss_rs = 5'd8;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy8_kept: got stall %b expected 1", stall); end
        idle_inputs();
    endtask

    task automatic test_starvation();
        $display("test_starvation");
        do_reset();
        mdu_valid = 1; mdu_dst = 5'd9; mdu_data = 32'h1234;
        wb_valid = 1; wb_dst = 5'd10; wb_data = 32'hAAAA;
        #1;
        checks++; if (mdu_ready !== 1'b1 || rf_rw !== 5'd10) begin errors++; $display("FAIL accept_cycle: got ready=%b rw=%0d expected 1/10", mdu_ready, rf_rw); end
        cyc();
        mdu_valid = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rf_rw !== 5'd10 || wb_hold !== 1'b0 || mdu_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_%0d: got rw=%0d hold=%b ready=%b expected 10/0/0", k, rf_rw, wb_hold, mdu_ready);
            end
            cyc();
        end
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rw !== 5'd9 || rf_busw !== 32'h1234) begin errors++; $display("FAIL preempt: got we=%b rw=%0d busw=%h expected 1/9/1234", rf_we, rf_rw, rf_busw); end
        checks++; if (wb_hold !== 1'b1 || mdu_ready !== 1'b1) begin errors++; $display("FAIL preempt_hold: got hold=%b ready=%b expected 1/1", wb_hold, mdu_ready); end
        cyc();
        #1;
        checks++; if (rf_rw !== 5'd10 || rf_busw !== 32'hAAAA || wb_hold !== 1'b0) begin errors++; $display("FAIL wb_after: got rw=%0d busw=%h hold=%b expected 10/aaaa/0", rf_rw, rf_busw, wb_hold); end
        idle_inputs();
    endtask

    task automatic test_mdu_full();
        $display("test_mdu_full");
        do_reset();
        iss_valid = 1; iss_long = 1; iss_wr = 1; iss_dst = 5'd12;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long1: got stall %b expected 0", stall); end
        cyc();
        iss_dst = 5'd13;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long2: got stall %b expected 0", stall); end
        cyc();
        iss_dst = 5'd14;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL long3_full: got stall %b expected 1", stall); end
        iss_long = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL short_not_full: got stall %b expected 0", stall); end
        iss_long = 1;
        mdu_valid = 1; mdu_dst = 5'd12; mdu_data = 32'h5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL accept_same_cycle: got stall %b expected 1", stall); end
        cyc();
        mdu_valid = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_dropped: got stall %b expected 0", stall); end
        checks++; if (rf_we !== 1'b1 || rf_rw !== 5'd12 || rf_busw !== 32'h5) begin errors++; $display("FAIL drain12: got we=%b rw=%0d busw=%h expected 1/12/5", rf_we, rf_rw, rf_busw); end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        $display("test_set_wins");
        do_reset();
        mdu_valid = 1; mdu_dst = 5'd7; mdu_data = 32'h77;
        cyc();
        mdu_valid = 0;
        iss_valid = 1; iss_wr = 1; iss_dst = 5'd7;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rw !== 5'd7 || rf_busw !== 32'h77) begin errors++; $display("FAIL drain7: got we=%b rw=%0d busw=%h expected 1/7/77", rf_we, rf_rw, rf_busw); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL issue_d7: got stall %b expected 0", stall); end
        cyc();
        iss_wr = 0; iss_dst = 0; iss_rs = 5'd7;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL set_wins_rs7: got stall %b expected 1", stall); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL port_idle: got rf_we %b expected 0", rf_we); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        $display("test_reset_mid");
        do_reset();
        iss_valid = 1; iss_wr = 1; iss_dst = 5'd3;
        cyc();
        iss_valid = 0; iss_wr = 0; iss_dst = 0;
        mdu_valid = 1; mdu_dst = 5'd8; mdu_data = 32'h88;
        wb_valid = 1; wb_dst = 5'd20; wb_data = 32'h20;
        cyc();
        mdu_valid = 0;
        #1;
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL buf_full: got mdu_ready %b expected 0", mdu_ready); end
        wb_valid = 0;
        reset = 0;
        #1;
        checks++; if (rf_we !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL mid_rst_force: got we=%b stall=%b expected 0/1", rf_we, stall); end
        cyc();
        reset = 1;
        iss_valid = 1; iss_rs = 5'd3;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL buf_discarded: got rf_we %b expected 0", rf_we); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b expected 1", mdu_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL busy3_cleared: got stall %b expected 0", stall); end
        idle_inputs();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_raw_writethrough();
        test_reg_zero();
        test_starvation();
        test_mdu_full();
        test_set_wins();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rf_write_scheduler
